// File: rtl/muxn_guard_reg.sv
// N-input, W-bit registered mux with select handshake and break-before-make guard.
// Define MUXN_GUARD_ZERO_EN to drive Z to zero during the guard interval.
module muxn_guard_reg #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int GUARD = 2,
  parameter int SW    = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic [N*W-1:0]  I,
  input  logic [SW-1:0]   S_REQ,
  input  logic            S_VALID,
  output logic            S_READY,
  output logic [SW-1:0]   S_CUR,
  output logic            BUSY,
  output logic            ERR,
  output logic [W-1:0]    Z
);

  typedef enum logic {ST_IDLE, ST_GUARD} state_t;

  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [SW:0] NMAX  = N[SW:0];
  localparam logic [3:0]  GLOAD = (GUARD > 0) ? 4'(GUARD - 1) : 4'd0;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [SW-1:0] pend, pend_n, cur_n;
  logic          err_n;
  logic [W-1:0]  z_n, sel_data;
  logic          accept, oor, same;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++)
      if (S_CUR == SW'(k)) sel_data = I[k*W +: W];
  end

  assign S_READY = (state == ST_IDLE) & RN;
  assign BUSY    = (state == ST_GUARD);
  assign accept  = S_VALID & S_READY;
  assign oor     = {1'b0, S_REQ} >= NMAX;
  assign same    = (S_REQ == S_CUR);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    cur_n   = S_CUR;
    err_n   = 1'b0;
    z_n     = Z;
    case (state)
      ST_IDLE: begin
        z_n = sel_data;
        if (accept) begin
          if (oor) begin
            err_n = 1'b1;
          end else if (!same) begin
            if (GUARD == 0) begin
              cur_n = S_REQ;
            end else begin
              pend_n  = S_REQ;
              cnt_n   = GLOAD;
              state_n = ST_GUARD;
            end
          end
        end
      end
      ST_GUARD: begin
`ifdef MUXN_GUARD_ZERO_EN
        z_n = '0;
`else
        z_n = Z;
`endif
        if (cnt == 4'd0) begin
          cur_n   = pend;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= '0;
      S_CUR <= '0;
      ERR   <= 1'b0;
      Z     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      S_CUR <= cur_n;
      ERR   <= err_n;
      Z     <= z_n;
    end
  end

endmodule

// File: tb/tb_muxn_guard_reg.sv
// Directed bench for muxn_guard_reg: four configurations driven from one sequence,
// expectations queued as stimulus is applied and popped when outputs are sampled.
module tb_muxn_guard_reg;

  // Instance map: 0 = N4/G2, 1 = N4/G0, 2 = N3/G2, 3 = N4/G5
  logic        clk;
  logic [31:0] din;
  logic        rn      [4];
  logic [1:0]  s_req   [4];
  logic        s_valid [4];
  logic        s_ready [4];
  logic [1:0]  s_cur   [4];
  logic        busy    [4];
  logic        err     [4];
  logic [7:0]  z       [4];

  muxn_guard_reg #(.N(4), .W(8), .GUARD(2)) u_g2 (
    .CLK(clk), .RN(rn[0]), .I(din), .S_REQ(s_req[0]), .S_VALID(s_valid[0]),
    .S_READY(s_ready[0]), .S_CUR(s_cur[0]), .BUSY(busy[0]), .ERR(err[0]), .Z(z[0]));
  muxn_guard_reg #(.N(4), .W(8), .GUARD(0)) u_g0 (
    .CLK(clk), .RN(rn[1]), .I(din), .S_REQ(s_req[1]), .S_VALID(s_valid[1]),
    .S_READY(s_ready[1]), .S_CUR(s_cur[1]), .BUSY(busy[1]), .ERR(err[1]), .Z(z[1]));
  muxn_guard_reg #(.N(3), .W(8), .GUARD(2)) u_n3 (
    .CLK(clk), .RN(rn[2]), .I(din[23:0]), .S_REQ(s_req[2]), .S_VALID(s_valid[2]),
    .S_READY(s_ready[2]), .S_CUR(s_cur[2]), .BUSY(busy[2]), .ERR(err[2]), .Z(z[2]));
  muxn_guard_reg #(.N(4), .W(8), .GUARD(5)) u_g5 (
    .CLK(clk), .RN(rn[3]), .I(din), .S_REQ(s_req[3]), .S_VALID(s_valid[3]),
    .S_READY(s_ready[3]), .S_CUR(s_cur[3]), .BUSY(busy[3]), .ERR(err[3]), .Z(z[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] hold(input logic [7:0] v);
`ifdef MUXN_GUARD_ZERO_EN
    return 8'h00;
`else
    return v;
`endif
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %0h with no expected entry", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 4; k++) begin
      rn[k] = 1'b0; s_req[k] = 2'd0; s_valid[k] = 1'b0;
    end

    // Reset held for two edges
    push("rst_z", 0); push("rst_ready", 0); push("rst_cur", 0);
    push("rst_busy", 0); push("rst_err", 0);
    tick(); tick();
    chk(32'(z[0])); chk(32'(s_ready[0])); chk(32'(s_cur[0]));
    chk(32'(busy[0])); chk(32'(err[0]));

    for (int k = 0; k < 4; k++) rn[k] = 1'b1;
    push("post_rst_z", 32'h11); push("post_rst_cur", 0); push("post_rst_ready", 1);
    push("post_rst_z_g5", 32'h11);
    tick();
    chk(32'(z[0])); chk(32'(s_cur[0])); chk(32'(s_ready[0])); chk(32'(z[3]));

    // One-cycle data latency
    din[7:0] = 8'hAA;
    push("latency_z", 32'hAA);
    tick();
    chk(32'(z[0]));
    din[7:0] = 8'h11;
    tick();

    // Guarded switch 0 -> 2 on GUARD=2
    s_req[0] = 2'd2; s_valid[0] = 1'b1;
    push("g2_e0_z", 32'h11); push("g2_e0_busy", 1); push("g2_e0_ready", 0);
    tick();
    chk(32'(z[0])); chk(32'(busy[0])); chk(32'(s_ready[0]));
    s_valid[0] = 1'b0;
    push("g2_e1_busy", 1); push("g2_e1_ready", 0); push("g2_e1_z", 32'(hold(8'h11)));
    push("g2_e1_cur", 0);
    tick();
    chk(32'(busy[0])); chk(32'(s_ready[0])); chk(32'(z[0])); chk(32'(s_cur[0]));
    push("g2_e2_busy", 0); push("g2_e2_ready", 1); push("g2_e2_cur", 2);
    push("g2_e2_z", 32'(hold(8'h11)));
    tick();
    chk(32'(busy[0])); chk(32'(s_ready[0])); chk(32'(s_cur[0])); chk(32'(z[0]));
    push("g2_e3_z", 32'h33);
    tick();
    chk(32'(z[0]));

    // Same-select on G2 (cur=2) and G0 (cur=0)
    s_req[0] = 2'd2; s_valid[0] = 1'b1;
    s_req[1] = 2'd0; s_valid[1] = 1'b1;
    push("same_g2_busy", 0); push("same_g2_ready", 1);
    push("same_g0_busy", 0); push("same_g0_ready", 1); push("same_g0_z", 32'h11);
    tick();
    chk(32'(busy[0])); chk(32'(s_ready[0]));
    chk(32'(busy[1])); chk(32'(s_ready[1])); chk(32'(z[1]));
    s_valid[0] = 1'b0;

    // GUARD=0 switch to 3
    s_req[1] = 2'd3;
    push("g0_cur", 3); push("g0_z_old", 32'h11); push("g0_busy", 0);
    tick();
    chk(32'(s_cur[1])); chk(32'(z[1])); chk(32'(busy[1]));
    s_valid[1] = 1'b0;
    push("g0_z_new", 32'h44);
    tick();
    chk(32'(z[1]));

    // Out-of-range request on N=3
    s_req[2] = 2'd3; s_valid[2] = 1'b1;
    push("oor_err", 1); push("oor_cur", 0); push("oor_busy", 0); push("oor_ready", 1);
    tick();
    chk(32'(err[2])); chk(32'(s_cur[2])); chk(32'(busy[2])); chk(32'(s_ready[2]));
    s_valid[2] = 1'b0;
    push("oor_err_clr", 0); push("oor_z", 32'h11);
    tick();
    chk(32'(err[2])); chk(32'(z[2]));

    // Reset in the third guard cycle of GUARD=5
    s_req[3] = 2'd1; s_valid[3] = 1'b1;
    push("g5_busy", 1);
    tick();
    chk(32'(busy[3]));
    s_valid[3] = 1'b0;
    tick();
    push("g5_busy_e2", 1);
    tick();
    chk(32'(busy[3]));
    rn[3] = 1'b0;
    push("g5_rst_cur", 0); push("g5_rst_busy", 0); push("g5_rst_z", 0); push("g5_rst_ready", 0);
    tick();
    chk(32'(s_cur[3])); chk(32'(busy[3])); chk(32'(z[3])); chk(32'(s_ready[3]));
    rn[3] = 1'b1;
    push("g5_after_ready", 1); push("g5_after_z", 32'h11);
    tick();
    chk(32'(s_ready[3])); chk(32'(z[3]));
    for (int k = 0; k < 6; k++) tick();
    push("g5_no_commit_cur", 0); push("g5_no_commit_busy", 0);
    chk(32'(s_cur[3])); chk(32'(busy[3]));

    // Held S_VALID across a guard on G2 (cur=2): switch to 0, then request 1
    s_req[0] = 2'd0; s_valid[0] = 1'b1;
    push("hv_e0_busy", 1);
    tick();
    chk(32'(busy[0]));
    s_req[0] = 2'd1;
    push("hv_e1_ready", 0);
    tick();
    chk(32'(s_ready[0]));
    push("hv_e2_cur", 0); push("hv_e2_busy", 0); push("hv_e2_ready", 1);
    tick();
    chk(32'(s_cur[0])); chk(32'(busy[0])); chk(32'(s_ready[0]));
    push("hv_e3_busy", 1); push("hv_e3_z", 32'h11); push("hv_e3_cur", 0);
    tick();
    chk(32'(busy[0])); chk(32'(z[0])); chk(32'(s_cur[0]));
    s_valid[0] = 1'b0;
    push("hv_e4_z", 32'(hold(8'h11)));
    tick();
    chk(32'(z[0]));
    push("hv_e5_cur", 1); push("hv_e5_busy", 0); push("hv_e5_err", 0);
    tick();
    chk(32'(s_cur[0])); chk(32'(busy[0])); chk(32'(err[0]));
    push("hv_e6_z", 32'h22);
    tick();
    chk(32'(z[0]));

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxn_guard_reg.md
# muxn_guard_reg

Parametrised N-input, W-bit registered multiplexer with a select-change handshake and break-before-make guard interval. It is the sequential successor to the combinational 4:1 mux cell. It targets datapath and configuration steering where a select change must never glitch between two live channels, and where the requester needs an explicit acknowledge. It sits between a control FSM that issues select requests and downstream logic that consumes the registered output Z.

## Interface
Parameters:
- N, default 4: number of input channels, 2..16.
- W, default 1: data width per channel, 1..64.
- GUARD, default 2: guard cycles inserted on a select change, 0..15.
- SW, derived as $clog2(N): select width.

Ports:
- CLK, input, 1: clock; all state updates on the rising edge.
- RN, input, 1: reset. Synchronous and active-low; CLK is the single clock.
- I, input, N*W: packed channel inputs; channel k occupies I[k*W +: W].
- S_REQ, input, SW: requested select value.
- S_VALID, input, 1: select request valid.
- S_READY, output, 1: block accepts a request; combinational from state, forced 0 while RN=0.
- S_CUR, output, SW: committed select, registered.
- BUSY, output, 1: high while in GUARD state.
- ERR, output, 1: one-cycle registered pulse when an out-of-range request (S_REQ >= N) is accepted.
- Z, output, W: registered mux output.

## Operation
- States: IDLE and GUARD. S_READY = (state==IDLE) & RN. BUSY = (state==GUARD).
- IDLE, every edge: Z <= channel S_CUR of I.
- A request is accepted at an edge where S_VALID & S_READY = 1.
- S_REQ >= N: request dropped and ERR=1 for one cycle. No state change.
- S_REQ == S_CUR: request acknowledged with no guard. State stays IDLE and Z is unaffected.
- GUARD=0, valid new select: S_CUR <= S_REQ at the accept edge. Z at that edge still samples the old channel.
- GUARD>0, valid new select: the pending select is latched, cnt <= GUARD-1, and state goes to GUARD.
- GUARD state, every edge: Z holds its value. If cnt==0, S_CUR <= pending and state goes to IDLE. Otherwise cnt decrements.
- S_VALID may stay high through GUARD. The request is not sampled until S_READY returns, and the requester must hold S_REQ stable until it is accepted.
- cnt width is 4 bits. GUARD itself is never reached as a count value, so cnt does not wrap.
- Reset takes effect at any edge with RN=0, including mid-GUARD; the pending select is discarded.
- Reset values: Z=0, S_CUR=0, state IDLE, cnt=0, ERR=0, BUSY=0, S_READY=0 while RN=0.

## Timing
- Data latency is 1 cycle: I changes before edge e, and Z reflects the change after e when in IDLE.
- Select change with the request accepted at edge e0:
  - Z samples the old channel at e0.
  - Z is held or zeroed at e1..eGUARD. BUSY is high and S_READY is low for exactly GUARD cycles.
  - S_CUR updates at eGUARD, and S_READY is high again after eGUARD.
  - Z shows the new channel after eGUARD+1.
- Back-to-back requests: a next request can be accepted at eGUARD+1 at the earliest.
- Same-select and out-of-range requests occupy a single cycle. S_READY stays high, so one request can be accepted per cycle.

## Configuration
- MUXN_GUARD_ZERO_EN defined: during GUARD edges, Z <= 0 (W'b0), giving a true break-before-make output.
- MUXN_GUARD_ZERO_EN undefined: during GUARD, Z holds the last value sampled from the old channel.
- The macro does not change handshake, S_CUR, BUSY or ERR timing.

## Test plan
- Reset and steady data: N=4, W=8, RN low for 2 cycles, then I={8'h44,8'h33,8'h22,8'h11}. Required: Z=0 during reset, and Z=8'h11 one edge after RN rises; S_CUR=0 and S_READY=1.
- Guarded switch: GUARD=2, request S_REQ=2 at e0. Required:
  - BUSY=1 and S_READY=0 for e1..e2.
  - Z=8'h11 held, or 0 with MUXN_GUARD_ZERO_EN.
  - S_CUR=2 after e2, and Z=8'h33 after e3.
- Same-select and GUARD=0: request S_REQ=0 while S_CUR=0. Required: no BUSY, S_READY stays 1.
  - With GUARD=0, request S_REQ=3: S_CUR=3 after the accept edge and Z=8'h44 one edge later.
- Out-of-range: N=3, S_REQ=3 accepted. Required: ERR=1 for exactly one cycle, S_CUR unchanged, no BUSY.
- Reset mid-guard: GUARD=5, switch to 1, drop RN at the 3rd guard cycle. Required: after reset, S_CUR=0, BUSY=0, Z=0; the pending select is never committed.
- Held S_VALID: S_VALID stays high across a guard with a second request S_REQ=1. Required: the second request is accepted only at eGUARD+1, and only one ERR or commit occurs per accept.
